// File: rtl/key_scan_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
package key_scan_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRESS_DB,
    SCAN,
    HIT,
    HOLD,
    REL_DB
  } state_t;

  localparam logic [3:0] ROW_ALL_LOW = 4'b0000;
  localparam logic [3:0] ROW_OFF     = 4'b1111;
  localparam logic [3:0] COL_NONE    = 4'b1111;

  // Active-low drive pattern that pulls exactly one row low.
  function automatic logic [3:0] row_sel(input logic [1:0] idx);
    return ~(4'b0001 << idx);
  endfunction

  // Number of columns pulled low (0..4).
  function automatic logic [2:0] low_count(input logic [3:0] c);
    logic [2:0] n;
    n = '0;
    for (int i = 0; i < 4; i++) n = n + {2'b00, ~c[i]};
    return n;
  endfunction

  // Index of the lowest-numbered low column; meaningful only when one is low.
  function automatic logic [1:0] col_idx(input logic [3:0] c);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--) if (!c[i]) idx = 2'(i);
    return idx;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running one-cycle pulse every CLK_FREQ/TICK_HZ clocks.
module tick_gen #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int TICK_HZ  = 1_000
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  output logic tick
);

  localparam int PERIOD = CLK_FREQ / TICK_HZ;
  localparam int CW     = (PERIOD > 1) ? $clog2(PERIOD) : 1;

  logic [CW-1:0] cnt;

  // Divide the clock down and emit a single-cycle pulse at wrap.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    // NOTE: sequential state is always assigned with <= so every register
    // samples pre-edge values regardless of statement order.
    if (!sys_rst_n) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (cnt == CW'(PERIOD - 1)) begin
      cnt  <= '0;
      tick <= 1'b1;
    end else begin
      cnt  <= cnt + 1'b1;
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/key_hex_scan.sv
// 4x4 matrix keypad scanner: debounced press/release, hex key code + strobe.
module key_hex_scan
  import key_scan_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int TICK_HZ  = 1_000,
  parameter int DB_TICKS = 20
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic [3:0] col,
  output logic [3:0] row,
  output logic [3:0] key_code,
  output logic       key_vld,
  output logic       key_down
);

  localparam int DBW = $clog2(DB_TICKS + 1);

  logic           tick;
  logic [3:0]     col_meta, col_s;
  state_t         state_q, state_d;
  logic [DBW-1:0] db_cnt_q, db_cnt_d;
  logic [1:0]     ridx_q, ridx_d;
  logic [3:0]     hit_code_q, hit_code_d;
  logic [3:0]     row_d;

  tick_gen #(
    .CLK_FREQ(CLK_FREQ),
    .TICK_HZ (TICK_HZ)
  ) u_tick_gen (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .tick     (tick)
  );

  // Two-stage synchronizer for the asynchronous column inputs.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      col_meta <= COL_NONE;
      col_s    <= COL_NONE;
    end else begin
      col_meta <= col;
      col_s    <= col_meta;
    end
  end

  // FSM state, counters, latched hit code and registered row drive.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q    <= IDLE;
      db_cnt_q   <= '0;
      ridx_q     <= 2'd0;
      hit_code_q <= 4'h0;
      row        <= ROW_OFF;
    end else begin
      state_q    <= state_d;
      db_cnt_q   <= db_cnt_d;
      ridx_q     <= ridx_d;
      hit_code_q <= hit_code_d;
      row        <= row_d;
    end
  end

  // Next-state logic; decisions are taken only on tick, except HIT.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // leaves a signal unassigned and no latch is inferred.
    state_d    = state_q;
    db_cnt_d   = db_cnt_q;
    ridx_d     = ridx_q;
    hit_code_d = hit_code_q;
    unique case (state_q)
      IDLE: if (tick && col_s != COL_NONE) begin
        state_d  = PRESS_DB;
        db_cnt_d = DBW'(1);
      end
      PRESS_DB: if (tick) begin
        if (col_s == COL_NONE)                state_d = IDLE;
        else if (db_cnt_q == DBW'(DB_TICKS)) begin
          state_d = SCAN;
          ridx_d  = 2'd0;
        end else                              db_cnt_d = db_cnt_q + 1'b1;
      end
      SCAN: if (tick) begin
        unique case (low_count(col_s))
          3'd0: begin
            if (ridx_q == 2'd3) state_d = IDLE;
            else                ridx_d  = ridx_q + 1'b1;
          end
          3'd1: begin
            state_d    = HIT;
            hit_code_d = {ridx_q, col_idx(col_s)};
          end
          default: state_d = IDLE;  // ghosting: several keys on one row
        endcase
      end
      HIT: state_d = HOLD;
      HOLD: if (tick && col_s == COL_NONE) begin
        state_d  = REL_DB;
        db_cnt_d = DBW'(1);
      end
      REL_DB: if (tick) begin
        if (col_s != COL_NONE)               state_d  = HOLD;
        else if (db_cnt_q == DBW'(DB_TICKS)) state_d  = IDLE;
        else                                 db_cnt_d = db_cnt_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase

    // Debounce count restarts on entry to any non-debounce state.
    if (state_d != state_q && state_d != PRESS_DB && state_d != REL_DB)
      db_cnt_d = '0;

    row_d = (state_d == SCAN) ? row_sel(ridx_d) : ROW_ALL_LOW;
  end

  // Output registers: strobe and code change together, key_down spans the hold.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      key_code <= 4'h0;
      key_vld  <= 1'b0;
      key_down <= 1'b0;
    end else begin
      key_vld <= (state_q == HIT);
      if (state_q == HIT) begin
        key_code <= hit_code_q;
        key_down <= 1'b1;
      end else if (state_q == REL_DB && state_d == IDLE) begin
        key_down <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_key_hex_scan.sv
// Directed bench for key_hex_scan with a behavioural 4x4 keypad matrix.
module tb_key_hex_scan;
  import key_scan_pkg::*;

  logic        sys_clk;
  logic        sys_rst_n;
  logic [3:0]  col;
  logic [3:0]  row;
  logic [3:0]  key_code;
  logic        key_vld;
  logic        key_down;
  logic [15:0] key_mask;  // bit 4*row+col set = that key pressed

  int n_checks = 0;
  int n_fail   = 0;
  int vld_cnt  = 0;
  bit dbl_vld  = 1'b0;
  logic vld_prev = 1'b0;

  key_hex_scan #(
    .CLK_FREQ(1000),
    .TICK_HZ (100),
    .DB_TICKS(3)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .col      (col),
    .row      (row),
    .key_code (key_code),
    .key_vld  (key_vld),
    .key_down (key_down)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // Keypad matrix: a pressed key shorts its column to a row driven low.
  always_comb begin
    col = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (key_mask[4*r+c] && !row[r]) col[c] = 1'b0;
  end

  // Strobe monitor: count pulses and flag back-to-back strobes.
  always @(posedge sys_clk) begin
    if (key_vld) vld_cnt++;
    if (key_vld && vld_prev) dbl_vld = 1'b1;
    vld_prev = key_vld;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic wait_vld(input int target, input int budget, input string tag);
    for (int i = 0; i < budget && vld_cnt < target; i++) @(negedge sys_clk);
    check(tag, vld_cnt, target);
  endtask

  task automatic wait_state(input state_t s, input int budget, input string tag);
    for (int i = 0; i < budget && dut.state_q != s; i++) @(negedge sys_clk);
    check(tag, 32'(dut.state_q), 32'(s));
  endtask

  task automatic wait_up(input int budget, input string tag);
    for (int i = 0; i < budget && key_down !== 1'b0; i++) @(negedge sys_clk);
    check(tag, key_down, 1'b0);
  endtask

  task automatic pulse_reset(input string tag);
    sys_rst_n = 1'b0;
    #1;
    check({tag, "_row"},  row,      4'b1111);
    check({tag, "_down"}, key_down, 1'b0);
    check({tag, "_vld"},  key_vld,  1'b0);
    check({tag, "_code"}, key_code, 4'h0);
    clks(3);
    sys_rst_n = 1'b1;
  endtask

  int base;

  initial begin
    sys_rst_n = 1'b0;
    key_mask  = '0;
    clks(2);
    check("rst_row",   row,      4'b1111);
    check("rst_code",  key_code, 4'h0);
    check("rst_vld",   key_vld,  1'b0);
    check("rst_down",  key_down, 1'b0);
    sys_rst_n = 1'b1;
    clks(20);
    check("idle_row",  row, 4'b0000);

    // 1: key 9 (row2,col1) held 200 clocks
    key_mask = 16'h0001 << 9;
    clks(200);
    check("k9_vld_cnt", vld_cnt,  1);
    check("k9_code",    key_code, 4'h9);
    check("k9_down",    key_down, 1'b1);
    check("k9_row",     row,      4'b0000);
    key_mask = '0;
    clks(15);
    check("k9_down_rel_db", key_down, 1'b1);
    clks(45);
    check("k9_up",       key_down, 1'b0);
    check("k9_row_idle", row,      4'b0000);
    check("k9_state",    32'(dut.state_q), 32'(IDLE));

    // 2: key 0 bouncing with one-tick pulses
    base = vld_cnt;
    for (int i = 0; i < 6; i++) begin
      key_mask = 16'h0001;
      clks(10);
      key_mask = '0;
      clks(10);
    end
    clks(20);
    check("bounce_vld",   vld_cnt, base);
    check("bounce_state", 32'(dut.state_q), 32'(IDLE));
    check("bounce_down",  key_down, 1'b0);

    // 3: ghost - keys E and F on the same row
    key_mask = (16'h0001 << 14) | (16'h0001 << 15);
    clks(150);
    check("ghost_vld",  vld_cnt,  base);
    check("ghost_code", key_code, 4'h9);
    check("ghost_down", key_down, 1'b0);
    key_mask = '0;
    clks(60);

    // 4: press F, release, press 4
    key_mask = 16'h0001 << 15;
    wait_vld(base + 1, 200, "kF_vld_wait");
    clks(2);
    check("kF_code", key_code, 4'hF);
    key_mask = '0;
    wait_up(100, "kF_up");
    key_mask = 16'h0001 << 4;
    wait_vld(base + 2, 200, "k4_vld_wait");
    clks(2);
    check("k4_code", key_code, 4'h4);
    check("k4_down", key_down, 1'b1);
    key_mask = '0;
    wait_up(100, "k4_up");
    clks(20);

    // 5: reset during SCAN and during HOLD with key 6 (row1,col2) held
    key_mask = 16'h0001 << 6;
    wait_state(SCAN, 200, "k6_reach_scan");
    base = vld_cnt;
    pulse_reset("rst_scan");
    clks(25);
    check("rst_scan_no_vld", vld_cnt, base);
    wait_vld(base + 1, 200, "k6_vld_wait");
    clks(2);
    check("k6_code", key_code, 4'h6);
    check("k6_state_hold", 32'(dut.state_q), 32'(HOLD));
    pulse_reset("rst_hold");
    clks(25);
    check("rst_hold_no_vld", vld_cnt, base + 1);
    wait_vld(base + 2, 200, "k6_revld_wait");
    key_mask = '0;
    wait_up(100, "k6_up");
    clks(20);

    // 6: one-tick release glitch while holding key 9
    base = vld_cnt;
    key_mask = 16'h0001 << 9;
    wait_vld(base + 1, 200, "g9_vld_wait");
    clks(20);
    key_mask = '0;
    wait_state(REL_DB, 40, "g9_reach_rel_db");
    key_mask = 16'h0001 << 9;
    clks(50);
    check("g9_down",  key_down, 1'b1);
    check("g9_vld",   vld_cnt,  base + 1);
    check("g9_state", 32'(dut.state_q), 32'(HOLD));
    key_mask = '0;
    wait_up(100, "g9_up");

    check("no_double_vld", dbl_vld, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
